// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes: physical tag width, sentinel tags,
// and the checkpoint page type used by the free list and the RAT.
package rename_pkg;
  localparam int PHYS_W    = 8;
  localparam int NUM_ARCH  = 32;
  localparam int NUM_TAGS  = 254;
  localparam int NUM_PAGES = 8;
  localparam int DEPTH     = 256;
  localparam int PTR_W     = 9;
  // Tags not mapped to an architectural register at reset.
  localparam int INIT_FREE = NUM_TAGS - NUM_ARCH;

  localparam logic [PHYS_W-1:0] TAG_NO_SRC = 8'd254;
  localparam logic [PHYS_W-1:0] TAG_NO_RD  = 8'd255;

  typedef logic [PHYS_W-1:0] phys_tag_t;
  typedef logic [2:0]        page_t;
  typedef logic [PTR_W-1:0]  ptr_t;
endpackage

// File: rtl/free_list_if.sv
// Rename <-> free list tag interface. The rename stage is the master;
// the free list is the slave.
interface free_list_if;
  import rename_pkg::*;

  logic        alloc_req;
  phys_tag_t   free_phy_addr;
  logic        free_valid;
  logic        release_valid;
  phys_tag_t   release_phy_addr;
  logic        save_state;
  page_t       save_page;
  logic        restore_state;
  page_t       restore_page;
  logic [8:0]  free_count;
  logic        overflow_err;
  logic [15:0] stall_count;

  modport master (
    output alloc_req, release_valid, release_phy_addr,
           save_state, save_page, restore_state, restore_page,
    input  free_phy_addr, free_valid, free_count, overflow_err, stall_count
  );

  modport slave (
    input  alloc_req, release_valid, release_phy_addr,
           save_state, save_page, restore_state, restore_page,
    output free_phy_addr, free_valid, free_count, overflow_err, stall_count
  );
endinterface

// File: rtl/free_list_ckpt.sv
// Per-branch head-pointer checkpoint store: one write port (save) and one
// combinational read port (restore), so a same-cycle restore sees the old value.
module free_list_ckpt
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we_i,
  input  page_t wpage_i,
  input  ptr_t  wdata_i,
  input  page_t rpage_i,
  output ptr_t  rdata_o
);
  ptr_t page_q [NUM_PAGES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PAGES; i++) page_q[i] <= '0;
    end else if (we_i) begin
      page_q[wpage_i] <= wdata_i;
    end
  end

  assign rdata_o = page_q[rpage_i];
endmodule

// File: rtl/free_list.sv
// Physical-register free list with per-branch head checkpoints.
// Optional stall counter enabled by defining FREE_LIST_STATS_EN.
module free_list
  import rename_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  free_list_if.slave bus
);
  phys_tag_t mem_q [DEPTH];
  ptr_t      head_q, head_d;
  ptr_t      tail_q, tail_d;
  logic      ovf_q, ovf_d;
  ptr_t      ckpt_head;
  ptr_t      count;
  logic      not_empty, full, tag_ok, pop, push;

  assign count     = tail_q - head_q;
  assign not_empty = (head_q != tail_q);
  assign full      = (count == PTR_W'(DEPTH));
  // Tag 0 is the permanent x0 mapping; 254/255 are sentinels, never recycled.
  assign tag_ok    = bus.release_valid && (bus.release_phy_addr != '0) &&
                     (bus.release_phy_addr < PHYS_W'(NUM_TAGS));
  assign pop       = bus.alloc_req && not_empty && !bus.restore_state;
  assign push      = tag_ok && !full;

  always_comb begin
    head_d = head_q;
    if (bus.restore_state) head_d = ckpt_head;
    else if (pop)          head_d = head_q + 1'b1;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    ovf_d  = ovf_q | (tag_ok && full);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= PTR_W'(INIT_FREE);
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= (i < INIT_FREE) ? PHYS_W'(NUM_ARCH + i) : '0;
    end else if (push) begin
      mem_q[tail_q[7:0]] <= bus.release_phy_addr;
    end
  end

  free_list_ckpt u_ckpt (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.save_state),
    .wpage_i (bus.save_page),
    .wdata_i (head_q),
    .rpage_i (bus.restore_page),
    .rdata_o (ckpt_head)
  );

  assign bus.free_phy_addr = not_empty ? mem_q[head_q[7:0]] : TAG_NO_RD;
  assign bus.free_valid    = not_empty;
  assign bus.free_count    = count;
  assign bus.overflow_err  = ovf_q;

`ifdef FREE_LIST_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.alloc_req && !not_empty && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = '0;
`endif
endmodule
